z85_prefix_seq: RTL and testbench

- Prefix-sequencing controller in front of the Z85 execute engine.
- Consumes the opcode byte stream from the fetch unit and walks the DD/FD/ED/CB and DD/FD+CB+d prefix chains.
- Emits one assembled instruction descriptor (group, index select, displacement, final opcode) per instruction, plus M1/refresh and interrupt-block qualifiers for the core.

---
 rtl/z85_decode_pkg.sv | 55 +++++
 rtl/z85_prefix_seq.sv | 143 ++++++++++++++
 tb/tb_z85_prefix_seq.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/z85_decode_pkg.sv
// z85_decode_pkg: shared Z85 decode types, prefix byte classifiers and sequencer state encoding
package z85_decode_pkg;

    localparam logic [7:0] P_DD = 8'hDD;
    localparam logic [7:0] P_FD = 8'hFD;
    localparam logic [7:0] P_ED = 8'hED;
    localparam logic [7:0] P_CB = 8'hCB;

    typedef enum logic [1:0] {
        GRP_BASE = 2'd0,
        GRP_CB   = 2'd1,
        GRP_ED   = 2'd2,
        GRP_DDCB = 2'd3
    } z85_grp_e;

    typedef enum logic [1:0] {
        IDX_HL = 2'd0,
        IDX_IX = 2'd1,
        IDX_IY = 2'd2
    } z85_idx_e;

    typedef enum logic [2:0] {
        S_OP     = 3'd0,
        S_IDX    = 3'd1,
        S_ED     = 3'd2,
        S_CB     = 3'd3,
        S_XCB_D  = 3'd4,
        S_XCB_OP = 3'd5,
        S_DISP   = 3'd6,
        S_HOLD   = 3'd7
    } z85_pseq_state_e;

    function automatic logic is_prefix_idx(input logic [7:0] b);
        return (b == P_DD) || (b == P_FD);
    endfunction

    function automatic logic is_prefix_ed(input logic [7:0] b);
        return b == P_ED;
    endfunction

    function automatic logic is_prefix_cb(input logic [7:0] b);
        return b == P_CB;
    endfunction

    // Base opcodes that address (HL); under DD/FD they become (IX+d)/(IY+d)
    // and need a displacement byte. 76 is HALT, not LD (HL),(HL).
    function automatic logic base_uses_hl_indirect(input logic [7:0] op);
        logic ld_src, ld_dst, alu;
        ld_src = (op[7:6] == 2'b01) && (op[2:0] == 3'b110) && (op != 8'h76);
        ld_dst = (op[7:6] == 2'b01) && (op[5:3] == 3'b110) && (op != 8'h76);
        alu    = (op[7:6] == 2'b10) && (op[2:0] == 3'b110);
        return (op == 8'h34) || (op == 8'h35) || (op == 8'h36) || ld_src || ld_dst || alu;
    endfunction

endpackage

// File: rtl/z85_prefix_seq.sv
// z85_prefix_seq: walks DD/FD/ED/CB prefix chains and emits one instruction descriptor per instruction
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   flush               abandon partial or pending instruction
//   byte_valid/ready    fetch byte handshake; byte_data is the byte
//   byte_m1             accepted byte is an M1 fetch (R increment)
//   ins_valid/ready     descriptor handshake to the execute engine
//   ins_grp/idx/op      group, index select (HL/IX/IY), final opcode
//   ins_disp/has_disp   signed displacement and whether it was fetched
//   int_block           mid-chain, interrupts must not be taken
//   prefix_redundant    redundant-prefix counter, present only with Z85_PREFIX_STATS_EN
module z85_prefix_seq
    import z85_decode_pkg::*;
#(
    parameter int STATS_W        = 16,
    parameter bit ED_CANCELS_IDX = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       byte_m1,
    output logic       ins_valid,
    input  logic       ins_ready,
    output logic [1:0] ins_grp,
    output logic [1:0] ins_idx,
    output logic [7:0] ins_op,
    output logic [7:0] ins_disp,
    output logic       ins_has_disp,
    output logic       int_block
`ifdef Z85_PREFIX_STATS_EN
    ,
    output logic [STATS_W-1:0] prefix_redundant
`endif
);

    if (STATS_W < 1) begin : g_bad_stats_w
        $error("STATS_W must be at least 1");
    end

    z85_pseq_state_e state_q;
    z85_grp_e        grp_q;
    z85_idx_e        idx_q;
    logic [7:0]      op_q;
    logic [7:0]      disp_q;
    logic            has_disp_q;
    logic            xfer;

    assign byte_ready   = !rst && (state_q != S_HOLD);
    assign xfer         = byte_valid && byte_ready && !flush;
    assign byte_m1      = xfer && (state_q inside {S_OP, S_IDX, S_ED, S_CB});
    assign int_block    = !(state_q inside {S_OP, S_HOLD});
    assign ins_valid    = state_q == S_HOLD;
    assign ins_grp      = grp_q;
    assign ins_idx      = idx_q;
    assign ins_op       = op_q;
    assign ins_disp     = disp_q;
    assign ins_has_disp = has_disp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_OP;
            grp_q      <= GRP_BASE;
            idx_q      <= IDX_HL;
            op_q       <= '0;
            disp_q     <= '0;
            has_disp_q <= 1'b0;
        end else if (flush || (state_q == S_HOLD && ins_ready)) begin
            state_q    <= S_OP;
            idx_q      <= IDX_HL;
            disp_q     <= '0;
            has_disp_q <= 1'b0;
        end else if (xfer) begin
            case (state_q)
                S_OP: begin
                    if (is_prefix_idx(byte_data)) begin
                        idx_q   <= (byte_data == P_DD) ? IDX_IX : IDX_IY;
                        state_q <= S_IDX;
                    end else if (is_prefix_ed(byte_data)) begin
                        state_q <= S_ED;
                    end else if (is_prefix_cb(byte_data)) begin
                        state_q <= S_CB;
                    end else begin
                        op_q    <= byte_data;
                        grp_q   <= GRP_BASE;
                        state_q <= S_HOLD;
                    end
                end
                S_IDX: begin
                    if (is_prefix_idx(byte_data)) begin
                        idx_q <= (byte_data == P_DD) ? IDX_IX : IDX_IY;
                    end else if (is_prefix_ed(byte_data)) begin
                        if (ED_CANCELS_IDX) idx_q <= IDX_HL;
                        state_q <= S_ED;
                    end else if (is_prefix_cb(byte_data)) begin
                        state_q <= S_XCB_D;
                    end else begin
                        // idx stays set so the engine substitutes IX/IY for HL
                        op_q    <= byte_data;
                        grp_q   <= GRP_BASE;
                        state_q <= base_uses_hl_indirect(byte_data) ? S_DISP : S_HOLD;
                    end
                end
                S_ED, S_CB: begin
                    op_q    <= byte_data;
                    grp_q   <= (state_q == S_ED) ? GRP_ED : GRP_CB;
                    state_q <= S_HOLD;
                end
                S_DISP, S_XCB_D: begin
                    disp_q     <= byte_data;
                    has_disp_q <= 1'b1;
                    state_q    <= (state_q == S_DISP) ? S_HOLD : S_XCB_OP;
                end
                S_XCB_OP: begin
                    op_q    <= byte_data;
                    grp_q   <= GRP_DDCB;
                    state_q <= S_HOLD;
                end
                default: state_q <= S_OP;
            endcase
        end
    end

`ifdef Z85_PREFIX_STATS_EN
    logic [STATS_W-1:0] stats_q;
    logic               stat_inc;

    // A repeated DD/FD overrides the previous one; an ED that drops the index
    // makes the earlier index prefix equally useless.
    assign stat_inc = xfer && (state_q == S_IDX) &&
                      (is_prefix_idx(byte_data) || (ED_CANCELS_IDX && is_prefix_ed(byte_data)));
    assign prefix_redundant = stats_q;

    always_ff @(posedge clk) begin
        if (rst) stats_q <= '0;
        else if (stat_inc && !(&stats_q)) stats_q <= stats_q + 1'b1;
    end
`endif

endmodule

// File: tb/tb_z85_prefix_seq.sv
// tb_z85_prefix_seq: directed self-checking bench for the Z85 prefix sequencer
module tb_z85_prefix_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_ready, byte_m1, ins_valid, ins_has_disp, int_block;
    logic       ins_ready = 1'b0;
    logic [1:0] ins_grp, ins_idx;
    logic [7:0] ins_op, ins_disp;
`ifdef Z85_PREFIX_STATS_EN
    logic [15:0] prefix_redundant;
`endif
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    z85_prefix_seq dut (
        .clk(clk), .rst(rst), .flush(flush),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .byte_m1(byte_m1),
        .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins_grp(ins_grp), .ins_idx(ins_idx), .ins_op(ins_op),
        .ins_disp(ins_disp), .ins_has_disp(ins_has_disp),
        .int_block(int_block)
`ifdef Z85_PREFIX_STATS_EN
        , .prefix_redundant(prefix_redundant)
`endif
    );

    // Presents one byte starting just after a negedge; returns m1/int_block seen
    // in the transfer cycle and ends just after the following negedge.
    task automatic send(input logic [7:0] b, output logic m1, output logic ib);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        #1;
        while (!byte_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (!byte_ready) begin
            bad++;
            $display("FAIL send_timeout byte=%h ready=%b required=1", b, byte_ready);
        end
        m1 = byte_m1;
        ib = int_block;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // Checks the pending descriptor, then performs the handshake.
    task automatic take(input string nm, input logic [1:0] g, input logic [1:0] ix,
                        input logic [7:0] op, input logic [7:0] d, input logic hd);
        int n = 0;
        #1;
        while (!ins_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (!ins_valid) begin
            bad++;
            $display("FAIL %s_valid got=%b required=1", nm, ins_valid);
        end
        total++;
        if ({ins_grp, ins_idx, ins_op} !== {g, ix, op}) begin
            bad++;
            $display("FAIL %s_desc got grp=%0d idx=%0d op=%h required grp=%0d idx=%0d op=%h",
                     nm, ins_grp, ins_idx, ins_op, g, ix, op);
        end
        total++;
        if ({ins_has_disp, (hd ? ins_disp : 8'h00)} !== {hd, d}) begin
            bad++;
            $display("FAIL %s_disp got has=%b d=%h required has=%b d=%h", nm, ins_has_disp, ins_disp, hd, d);
        end
        ins_ready = 1'b1;
        @(negedge clk);
        ins_ready = 1'b0;
        #1;
        total++;
        if ({ins_valid, byte_ready} !== 2'b01) begin
            bad++;
            $display("FAIL %s_release got valid=%b ready=%b required valid=0 ready=1", nm, ins_valid, byte_ready);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (byte_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready got=%b required=0", byte_ready);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({ins_valid, int_block, byte_ready, ins_grp, ins_idx, ins_op, ins_has_disp} !== {3'b001, 2'd0, 2'd0, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got valid=%b blk=%b ready=%b grp=%0d idx=%0d op=%h hd=%b required 0 0 1 0 0 00 0",
                     ins_valid, int_block, byte_ready, ins_grp, ins_idx, ins_op, ins_has_disp);
        end
        @(negedge clk);
    endtask

    task automatic test_base;
        logic m1, ib;
        send(8'h3E, m1, ib);
        total++;
        if ({m1, ib} !== 2'b10) begin
            bad++;
            $display("FAIL base_m1 got m1=%b blk=%b required m1=1 blk=0", m1, ib);
        end
        // 05 offered while the descriptor is pending must not be taken
        byte_valid = 1'b1;
        byte_data  = 8'h05;
        #1;
        total++;
        if ({ins_valid, byte_ready} !== 2'b10) begin
            bad++;
            $display("FAIL base_hold got valid=%b ready=%b required valid=1 ready=0", ins_valid, byte_ready);
        end
        byte_valid = 1'b0;
        take("base", 2'd0, 2'd0, 8'h3E, 8'h00, 1'b0);
        @(negedge clk);
        #1;
        total++;
        if (ins_valid !== 1'b0) begin
            bad++;
            $display("FAIL base_single got valid=%b required=0", ins_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_ix_disp;
        logic [2:0] m1, ib;
        send(8'hDD, m1[0], ib[0]);
        send(8'h7E, m1[1], ib[1]);
        send(8'hFE, m1[2], ib[2]);
        total++;
        if (m1 !== 3'b011) begin
            bad++;
            $display("FAIL ix_m1 got=%b required=011", m1);
        end
        total++;
        if (ib !== 3'b110) begin
            bad++;
            $display("FAIL ix_int_block got=%b required=110", ib);
        end
        take("ix_disp", 2'd0, 2'd1, 8'h7E, 8'hFE, 1'b1);
    endtask

    task automatic test_ddcb;
        logic [3:0] m1, ib;
        send(8'hFD, m1[0], ib[0]);
        send(8'hCB, m1[1], ib[1]);
        send(8'h03, m1[2], ib[2]);
        send(8'hC6, m1[3], ib[3]);
        total++;
        if (m1 !== 4'b0011) begin
            bad++;
            $display("FAIL ddcb_m1 got=%b required=0011", m1);
        end
        take("ddcb", 2'd3, 2'd2, 8'hC6, 8'h03, 1'b1);
    endtask

    task automatic test_ed_cancel;
        logic m1, ib;
        send(8'hDD, m1, ib);
        send(8'hFD, m1, ib);
        send(8'hDD, m1, ib);
        send(8'hED, m1, ib);
        send(8'hB0, m1, ib);
        total++;
        if (m1 !== 1'b1) begin
            bad++;
            $display("FAIL ed_m1 got=%b required=1", m1);
        end
`ifdef Z85_PREFIX_STATS_EN
        total++;
        if (prefix_redundant !== 16'd3) begin
            bad++;
            $display("FAIL stats got=%0d required=3", prefix_redundant);
        end
`endif
        take("ed_cancel", 2'd2, 2'd0, 8'hB0, 8'h00, 1'b0);
    endtask

    task automatic test_prefix_as_op;
        logic m1, ib;
        send(8'hED, m1, ib);
        send(8'hDD, m1, ib);
        take("ed_dd", 2'd2, 2'd0, 8'hDD, 8'h00, 1'b0);
        send(8'hFD, m1, ib);
        send(8'h21, m1, ib);
        take("iy_nodisp", 2'd0, 2'd2, 8'h21, 8'h00, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic m1, ib;
        send(8'hCB, m1, ib);
        send(8'h11, m1, ib);
        byte_valid = 1'b1;
        byte_data  = 8'h22;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if ({byte_ready, ins_valid, ins_grp, ins_idx, ins_op} !== {2'b01, 2'd1, 2'd0, 8'h11}) begin
                bad++;
                $display("FAIL stall_%0d got ready=%b valid=%b grp=%0d idx=%0d op=%h required 0 1 1 0 11",
                         i, byte_ready, ins_valid, ins_grp, ins_idx, ins_op);
            end
            @(negedge clk);
        end
        byte_valid = 1'b0;
        take("stall", 2'd1, 2'd0, 8'h11, 8'h00, 1'b0);
    endtask

    task automatic test_flush;
        logic m1, ib;
        send(8'hDD, m1, ib);
        flush      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h21;
        @(negedge clk);
        flush      = 1'b0;
        byte_valid = 1'b0;
        #1;
        total++;
        if ({ins_valid, int_block, byte_ready} !== 3'b001) begin
            bad++;
            $display("FAIL flush_state got valid=%b blk=%b ready=%b required 0 0 1", ins_valid, int_block, byte_ready);
        end
        @(negedge clk);
        #1;
        total++;
        if (ins_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_drop got valid=%b required=0", ins_valid);
        end
        send(8'h00, m1, ib);
        take("after_flush", 2'd0, 2'd0, 8'h00, 8'h00, 1'b0);
        // flush also drops a pending descriptor
        send(8'h3C, m1, ib);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        total++;
        if (ins_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_hold got valid=%b required=0", ins_valid);
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_base();
        test_ix_disp();
        test_ddcb();
        test_ed_cancel();
        test_prefix_as_op();
        test_back_to_back();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
